// File: rtl/spi_slave_sync_if.sv
// SPI bus bundle between an external master and spi_slave_sync.
// SS is active-low; mode 0 (SCLK idles low).
interface spi_slave_sync_if;
    logic SCLK;
    logic MOSI;
    logic SS;
    logic MISO;

    modport master (output SCLK, output MOSI, output SS, input MISO);
    modport slave  (input SCLK, input MOSI, input SS, output MISO);
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first, with all bus inputs resynchronised to clk.
// Optional overrun flag rx_ovr is built when SPI_SLAVE_SYNC_OVERRUN_EN is defined.
module spi_slave_sync #(
    parameter int         width        = 8,
    parameter logic [1:0] number_slave = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_data,
    input  logic [width-1:0] data,
    output logic [width-1:0] s_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [1:0]       my_id,
    spi_slave_sync_if.slave  spi
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    ,
    output logic             rx_ovr
`endif
);

    localparam int CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

    state_e           state_q, state_d;
    logic             sclk_s1_q, sclk_s2_q, sclk_dly_q;
    logic             sclk_s1_d, sclk_s2_d, sclk_dly_d;
    logic             mosi_s1_q, mosi_s2_q;
    logic             mosi_s1_d, mosi_s2_d;
    logic             ss_s1_q, ss_s2_q, ss_dly_q;
    logic             ss_s1_d, ss_s2_d, ss_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [width-1:0] rx_shift_q, rx_shift_d;
    logic [width-1:0] tx_shift_q, tx_shift_d;
    logic [width-1:0] tx_buf_q, tx_buf_d;
    logic [width-1:0] s_data_q, s_data_d;
    logic             done_q, done_d;
    logic             rx_valid_q, rx_valid_d;
    logic             sclk_rise, sclk_fall, ss_fall;

    assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s2_q & sclk_dly_q;
    assign ss_fall   = ~ss_s2_q & ss_dly_q;

    always_comb begin
        sclk_s1_d  = spi.SCLK;
        sclk_s2_d  = sclk_s1_q;
        sclk_dly_d = sclk_s2_q;
        mosi_s1_d  = spi.MOSI;
        mosi_s2_d  = mosi_s1_q;
        ss_s1_d    = spi.SS;
        ss_s2_d    = ss_s1_q;
        ss_dly_d   = ss_s2_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        s_data_d   = s_data_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;

        if (up_data) begin
            tx_buf_d = data;
        end

        // The completed word is published one cycle after its last bit is shifted in.
        if (done_q) begin
            s_data_d   = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        if (ss_s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (ss_fall) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cnt_d      = '0;
                    tx_shift_d = up_data ? data : tx_buf_q;
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[width-2:0], mosi_s2_q};
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            state_d = LOAD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (sclk_fall && (cnt_q != '0)) begin
                        // A fall with a zero count trails a word boundary; the fresh MSB must stay put.
                        tx_shift_d = {tx_shift_q[width-2:0], 1'b0};
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_dly_q <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            ss_s1_q    <= 1'b1;
            ss_s2_q    <= 1'b1;
            ss_dly_q   <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            s_data_q   <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            sclk_s1_q  <= sclk_s1_d;
            sclk_s2_q  <= sclk_s2_d;
            sclk_dly_q <= sclk_dly_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            ss_s1_q    <= ss_s1_d;
            ss_s2_q    <= ss_s2_d;
            ss_dly_q   <= ss_dly_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            s_data_q   <= s_data_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign s_data   = s_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);
    assign my_id    = number_slave;
    assign spi.MISO = (state_q == IDLE) ? 1'b0 : tx_shift_q[width-1];

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic unread_q, unread_d;
    logic rx_ovr_q, rx_ovr_d;

    // A word stays unread until an up_data strobe follows its rx_valid.
    always_comb begin
        unread_d = unread_q;
        rx_ovr_d = rx_ovr_q;
        if (up_data) begin
            unread_d = 1'b0;
            rx_ovr_d = 1'b0;
        end
        if (done_q) begin
            unread_d = 1'b1;
            if (unread_q && !up_data) begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unread_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            unread_q <= unread_d;
            rx_ovr_q <= rx_ovr_d;
        end
    end

    assign rx_ovr = rx_ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: bit-banged SPI master plus rx scoreboard.
// Build with SPI_SLAVE_SYNC_OVERRUN_EN defined to also exercise rx_ovr.
module tb_spi_slave_sync;

    localparam logic [1:0] SLAVE_ID = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_data;
    logic [7:0] data;
    logic [7:0] s_data;
    logic       rx_valid;
    logic       busy;
    logic [1:0] my_id;
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic       rx_ovr;
`endif

    spi_slave_sync_if bus();

    spi_slave_sync #(.width(8), .number_slave(SLAVE_ID)) dut (
        .clk      (clk),
        .rst      (rst),
        .up_data  (up_data),
        .data     (data),
        .s_data   (s_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .my_id    (my_id),
        .spi      (bus.slave)
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        ,
        .rx_ovr   (rx_ovr)
`endif
    );

    always #5 clk = ~clk;

    int         tests    = 0;
    int         errors   = 0;
    int         rx_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // Scoreboard: every rx_valid pops the next expected word.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_count++;
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: s_data=%h with no word expected", s_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (s_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_word: s_data=%h, expected %h", s_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_buf(input logic [7:0] v);
        @(negedge clk);
        up_data = 1'b1;
        data    = v;
        @(negedge clk);
        up_data = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge clk);
        bus.SS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge clk);
        bus.SS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side of one word at SCLK = clk/8; lat counts clk edges from raw SCLK high to rx_valid.
    task automatic xfer(input logic [7:0] mtx, input int nbits, input bit reload,
                        input logic [7:0] rval, output logic [7:0] mrx, output int lat);
        mrx = '0;
        lat = 0;
        if (nbits == 8) exp_q.push_back(mtx);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = mtx[7-i];
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (reload && i == 3 && k == 0) begin
                    up_data = 1'b1;
                    data    = rval;
                end else begin
                    up_data = 1'b0;
                end
            end
            bus.SCLK = 1'b1;
            mrx = {mrx[6:0], bus.MISO};
            if (nbits == 8 && i == 7) begin
                for (int k = 1; k <= 4; k++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid === 1'b1 && lat == 0) lat = k;
                end
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; up_data = 1'b0; data = '0;
        bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (s_data !== 8'h00) begin errors++; $display("FAIL reset_s_data: got %h, expected 00", s_data); end
        tests++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, expected 0", bus.MISO); end
        tests++; if (my_id !== SLAVE_ID) begin errors++; $display("FAIL my_id: got %b, expected %b", my_id, SLAVE_ID); end
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        tests++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL reset_rx_ovr: got %b, expected 0", rx_ovr); end
`endif
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] mrx; int lat; int c0;
        c0 = rx_count;
        load_buf(8'hA5);
        ss_low();
        xfer(8'h3C, 8, 1'b0, 8'h00, mrx, lat);
        ss_high();
        tests++; if (mrx !== 8'hA5) begin errors++; $display("FAIL single_miso: master got %h, expected A5", mrx); end
        tests++; if (lat != 4) begin errors++; $display("FAIL single_latency: rx_valid at edge %0d, expected 4", lat); end
        tests++; if (rx_count - c0 != 1) begin errors++; $display("FAIL single_pulses: got %0d, expected 1", rx_count - c0); end
        tests++; if (s_data !== 8'h3C) begin errors++; $display("FAIL single_s_data: got %h, expected 3C", s_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1, m2; int lat; int c0;
        c0 = rx_count;
        load_buf(8'h10);
        ss_low();
        xfer(8'h01, 8, 1'b1, 8'h20, m0, lat);
        xfer(8'h02, 8, 1'b0, 8'h00, m1, lat);
        xfer(8'h03, 8, 1'b0, 8'h00, m2, lat);
        ss_high();
        tests++; if (m0 !== 8'h10) begin errors++; $display("FAIL b2b_miso0: got %h, expected 10", m0); end
        tests++; if (m1 !== 8'h20) begin errors++; $display("FAIL b2b_miso1: got %h, expected 20", m1); end
        tests++; if (m2 !== 8'h20) begin errors++; $display("FAIL b2b_miso2: got %h, expected 20", m2); end
        tests++; if (rx_count - c0 != 3) begin errors++; $display("FAIL b2b_pulses: got %0d, expected 3", rx_count - c0); end
        tests++; if (s_data !== 8'h03) begin errors++; $display("FAIL b2b_s_data: got %h, expected 03", s_data); end
    endtask

    task automatic test_abort();
        logic [7:0] mrx; int lat; int c0;
        c0 = rx_count;
        ss_low();
        xfer(8'hE7, 5, 1'b0, 8'h00, mrx, lat);
        @(negedge clk);
        bus.SS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        repeat (8) @(negedge clk);
        tests++; if (rx_count != c0) begin errors++; $display("FAIL abort_pulses: got %0d, expected 0", rx_count - c0); end
        tests++; if (s_data !== 8'h03) begin errors++; $display("FAIL abort_s_data: got %h, expected 03", s_data); end
        ss_low();
        xfer(8'hFF, 8, 1'b0, 8'h00, mrx, lat);
        ss_high();
        tests++; if (mrx !== 8'h20) begin errors++; $display("FAIL abort_next_miso: got %h, expected 20", mrx); end
        tests++; if (s_data !== 8'hFF) begin errors++; $display("FAIL abort_next_s_data: got %h, expected FF", s_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mrx; int lat;
        ss_low();
        xfer(8'h81, 4, 1'b0, 8'h00, mrx, lat);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (s_data !== 8'h00) begin errors++; $display("FAIL rstmid_s_data: got %h, expected 00", s_data); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        tests++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b, expected 0", bus.MISO); end
        tests++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b, expected 0", rx_valid); end
        bus.SS = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        ss_low();
        xfer(8'h5A, 8, 1'b0, 8'h00, mrx, lat);
        ss_high();
        tests++; if (mrx !== 8'h00) begin errors++; $display("FAIL rstmid_miso_word: got %h, expected 00", mrx); end
        tests++; if (s_data !== 8'h5A) begin errors++; $display("FAIL rstmid_s_data_next: got %h, expected 5A", s_data); end
    endtask

    task automatic test_bypass();
        logic [7:0] m0, m1; int lat;
        @(negedge clk);
        bus.SS = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_load_busy: got %b, expected 0", busy); end
        up_data = 1'b1;
        data    = 8'hC3;
        @(negedge clk);
        up_data = 1'b0;
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL bypass_shift_busy: got %b, expected 1", busy); end
        repeat (3) @(negedge clk);
        xfer(8'h66, 8, 1'b0, 8'h00, m0, lat);
        xfer(8'h99, 8, 1'b0, 8'h00, m1, lat);
        ss_high();
        tests++; if (m0[7] !== 1'b1) begin errors++; $display("FAIL bypass_first_bit: got %b, expected 1", m0[7]); end
        tests++; if (m0 !== 8'hC3) begin errors++; $display("FAIL bypass_word: got %h, expected C3", m0); end
        tests++; if (m1 !== 8'hC3) begin errors++; $display("FAIL bypass_resend: got %h, expected C3", m1); end
        tests++; if (s_data !== 8'h99) begin errors++; $display("FAIL bypass_s_data: got %h, expected 99", s_data); end
    endtask

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    task automatic test_overrun();
        logic [7:0] mrx; int lat;
        load_buf(8'h11);
        tests++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear0: got %b, expected 0", rx_ovr); end
        ss_low();
        xfer(8'h21, 8, 1'b0, 8'h00, mrx, lat);
        tests++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b, expected 0", rx_ovr); end
        xfer(8'h22, 8, 1'b0, 8'h00, mrx, lat);
        ss_high();
        tests++; if (rx_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, expected 1", rx_ovr); end
        load_buf(8'h33);
        tests++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b, expected 0", rx_ovr); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_bypass();
`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
        test_overrun();
`endif
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
